// File: rtl/chiptune_pkg.sv
// chiptune_pkg: shared types and constants for the chiptune command path.
// Holds the sequencer state enum, header bit positions and the APU address limit.
package chiptune_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } seq_state_e;

    localparam int unsigned SYNC_BIT = 7;
    localparam int unsigned D7_BIT   = 6;
    localparam int unsigned RSV_BIT  = 5;

    localparam logic [4:0] APU_ADDR_MAX = 5'h17;

    // A header is usable when the reserved bit is clear and the address is in range.
    function automatic logic header_ok(input logic [7:0] b);
        return (b[RSV_BIT] == 1'b0) && (b[4:0] <= APU_ADDR_MAX);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: holds out high for CYCLES clocks after the most recent trig.
// A trig while already active restarts the full countdown.
module pulse_stretch #(
    parameter int unsigned CYCLES = 600_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic out
);

    localparam int unsigned CNT_W = $clog2(CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on trigger, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (trig) begin
            cnt_d = CNT_W'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/apu_reg_sequencer.sv
// apu_reg_sequencer: turns 2-byte UART frames into held APU register writes.
// Header: bit7=1, bit6=data[7], bit5=reserved(0), bits4:0=addr. Data: bit7=0, bits6:0.
// Optional feature macro: FRAME_STATS_EN enables the saturating err_count.
module apu_reg_sequencer
    import chiptune_pkg::*;
#(
    parameter int unsigned OSCRATE    = 12_000_000,
    parameter int unsigned TIMEOUT_MS = 2,
    parameter int unsigned LINK_MS    = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       reg_ready,
    output logic       reg_wr,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       link,
    output logic [7:0] err_count
);

    localparam int unsigned TIMEOUT_CYCLES = OSCRATE / 1000 * TIMEOUT_MS;
    localparam int unsigned LINK_CYCLES    = OSCRATE / 1000 * LINK_MS;
    localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES) + 1;

    seq_state_e       state_q, state_d;
    logic [4:0]       hdr_addr_q, hdr_addr_d;
    logic             hdr_d7_q, hdr_d7_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       reg_data_q, reg_data_d;

    logic is_hdr;
    logic hdr_good;
    logic frame_done;
    logic frame_err;
    logic slot_load;
    logic overrun;
    logic err_event;

    assign is_hdr   = rx_data[SYNC_BIT];
    assign hdr_good = header_ok(rx_data);

    // Frame FSM: header/data assembly, resync on any header, header-to-data timeout.
    // An incoming byte is examined before the timeout so data on the expiry cycle wins.
    always_comb begin
        state_d    = state_q;
        hdr_addr_d = hdr_addr_q;
        hdr_d7_d   = hdr_d7_q;
        tmo_d      = tmo_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (is_hdr && hdr_good) begin
                        state_d    = DATA;
                        hdr_addr_d = rx_data[4:0];
                        hdr_d7_d   = rx_data[D7_BIT];
                        tmo_d      = '0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (is_hdr) begin
                        frame_err = 1'b1;
                        if (hdr_good) begin
                            hdr_addr_d = rx_data[4:0];
                            hdr_d7_d   = rx_data[D7_BIT];
                            tmo_d      = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
        endcase
    end

    // One-deep write slot: load when empty or freeing this cycle, otherwise drop as overrun.
    always_comb begin
        reg_wr_d   = reg_wr_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        slot_load  = frame_done && (!reg_wr_q || reg_ready);
        overrun    = frame_done && reg_wr_q && !reg_ready;
        if (slot_load) begin
            reg_wr_d   = 1'b1;
            reg_addr_d = hdr_addr_q;
            reg_data_d = {hdr_d7_q, rx_data[6:0]};
        end else if (reg_wr_q && reg_ready) begin
            reg_wr_d = 1'b0;
        end
    end

    assign err_event = frame_err || overrun;

    // FSM and slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdr_addr_q <= '0;
            hdr_d7_q   <= 1'b0;
            tmo_q      <= '0;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_addr_q <= hdr_addr_d;
            hdr_d7_q   <= hdr_d7_d;
            tmo_q      <= tmo_d;
            reg_wr_q   <= reg_wr_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign reg_wr   = reg_wr_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;

`ifdef FRAME_STATS_EN
    logic [7:0] err_q, err_d;

    // Saturating error count; at most one error event exists per cycle.
    always_comb begin
        err_d = err_q;
        if (err_event && (err_q != '1)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
    assign err_count        = '0;
`endif

    pulse_stretch #(
        .CYCLES(LINK_CYCLES)
    ) u_link (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (slot_load),
        .out  (link)
    );

endmodule

// File: tb/tb_apu_reg_sequencer.sv
// tb_apu_reg_sequencer: directed scenarios for apu_reg_sequencer with scaled-down timing.
// OSCRATE=10_000 gives 10 cycles/ms: TIMEOUT_CYCLES=20, LINK_CYCLES=50.
module tb_apu_reg_sequencer;

    localparam int unsigned T_CYC = 20;
    localparam int unsigned L_CYC = 50;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       reg_ready;
    logic       reg_wr;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       link;
    logic [7:0] err_count;

    int n_cmp;
    int n_bad;
    int exp_err;
    int wr_count;

    apu_reg_sequencer #(
        .OSCRATE   (10_000),
        .TIMEOUT_MS(2),
        .LINK_MS   (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .reg_ready(reg_ready),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .link     (link),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted handshakes.
    always @(posedge clk) begin
        if (rst_n && reg_wr && reg_ready) wr_count <= wr_count + 1;
    end

    function automatic logic [7:0] err_want();
`ifdef FRAME_STATS_EN
        return (exp_err > 255) ? 8'd255 : 8'(exp_err);
`else
        return 8'd0;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        exp_err = 0;
        @(negedge clk);
        wr_count = 0;
    endtask

    task automatic test_reset();
        rx_valid = 1'b0; rx_data = 8'h00; reg_ready = 1'b0;
        do_reset();
        n_cmp++;
        if ({reg_wr, reg_addr, reg_data, link, err_count} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset: got wr=%b addr=%h data=%h link=%b err=%0d want all 0",
                     reg_wr, reg_addr, reg_data, link, err_count);
        end
    endtask

    task automatic test_write();
        reg_ready = 1'b1;
        send_byte(8'h80);
        send_byte(8'h3F);
        n_cmp++;
        if (reg_wr !== 1'b1 || reg_addr !== 5'h00 || reg_data !== 8'h3F || link !== 1'b1) begin
            n_bad++;
            $display("FAIL write: got wr=%b addr=%h data=%h link=%b want 1 00 3f 1",
                     reg_wr, reg_addr, reg_data, link);
        end
        idle(1);
        n_cmp++;
        if (reg_wr !== 1'b0 || wr_count !== 1) begin
            n_bad++;
            $display("FAIL write_pulse: got wr=%b count=%0d want 0 1", reg_wr, wr_count);
        end
        n_cmp++;
        if (err_count !== err_want()) begin
            n_bad++;
            $display("FAIL write_err: got %0d want %0d", err_count, err_want());
        end
    endtask

    task automatic test_d7();
        reg_ready = 1'b1;
        send_byte(8'hD5);
        send_byte(8'h12);
        n_cmp++;
        if (reg_wr !== 1'b1 || reg_addr !== 5'h15 || reg_data !== 8'h92) begin
            n_bad++;
            $display("FAIL d7: got wr=%b addr=%h data=%h want 1 15 92", reg_wr, reg_addr, reg_data);
        end
        idle(1);
    endtask

    task automatic test_held();
        int stable_bad;
        int c0;
        stable_bad = 0;
        reg_ready = 1'b0;
        c0 = wr_count;
        send_byte(8'h85);
        send_byte(8'h11);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                send_byte(8'h86);
            end else if (i == 4) begin
                send_byte(8'h22);
                exp_err++;
            end else begin
                idle(1);
            end
            if (reg_wr !== 1'b1 || reg_addr !== 5'h05 || reg_data !== 8'h11) stable_bad++;
        end
        n_cmp++;
        if (stable_bad !== 0) begin
            n_bad++;
            $display("FAIL held_stable: %0d unstable cycles, want 0 (last wr=%b addr=%h data=%h)",
                     stable_bad, reg_wr, reg_addr, reg_data);
        end
        n_cmp++;
        if (err_count !== err_want()) begin
            n_bad++;
            $display("FAIL held_overrun_err: got %0d want %0d", err_count, err_want());
        end
        reg_ready = 1'b1;
        idle(3);
        n_cmp++;
        if (reg_wr !== 1'b0 || wr_count - c0 !== 1) begin
            n_bad++;
            $display("FAIL held_release: got wr=%b writes=%0d want 0 1", reg_wr, wr_count - c0);
        end
    endtask

    task automatic test_back_to_back();
        reg_ready = 1'b0;
        send_byte(8'h8A);
        send_byte(8'h01);
        send_byte(8'h8B);
        reg_ready = 1'b1;
        send_byte(8'h02);
        n_cmp++;
        if (reg_wr !== 1'b1 || reg_addr !== 5'h0B || reg_data !== 8'h02 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL b2b_load: got wr=%b addr=%h data=%h err=%0d want 1 0b 02 %0d",
                     reg_wr, reg_addr, reg_data, err_count, err_want());
        end
        idle(1);
        n_cmp++;
        if (reg_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_free: got wr=%b want 0", reg_wr);
        end
    endtask

    task automatic test_timeout();
        int c0;
        reg_ready = 1'b1;
        c0 = wr_count;
        send_byte(8'h81);
        idle(T_CYC);
        send_byte(8'h05);
        exp_err += 2;
        idle(1);
        n_cmp++;
        if (wr_count !== c0 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL timeout_late: got writes=%0d err=%0d want 0 %0d",
                     wr_count - c0, err_count, err_want());
        end
        send_byte(8'h81);
        idle(T_CYC - 1);
        send_byte(8'h05);
        n_cmp++;
        if (reg_wr !== 1'b1 || reg_addr !== 5'h01 || reg_data !== 8'h05 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL timeout_edge: got wr=%b addr=%h data=%h err=%0d want 1 01 05 %0d",
                     reg_wr, reg_addr, reg_data, err_count, err_want());
        end
        idle(1);
    endtask

    task automatic test_bad_headers();
        int c0;
        reg_ready = 1'b1;
        c0 = wr_count;
        send_byte(8'hA3);
        send_byte(8'h98);
        send_byte(8'h82);
        send_byte(8'h83);
        send_byte(8'h01);
        exp_err += 3;
        n_cmp++;
        if (reg_wr !== 1'b1 || reg_addr !== 5'h03 || reg_data !== 8'h01 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL bad_hdr: got wr=%b addr=%h data=%h err=%0d want 1 03 01 %0d",
                     reg_wr, reg_addr, reg_data, err_count, err_want());
        end
        idle(1);
        n_cmp++;
        if (wr_count - c0 !== 1) begin
            n_bad++;
            $display("FAIL bad_hdr_count: got %0d writes want 1", wr_count - c0);
        end
        send_byte(8'h82);
        send_byte(8'hB0);
        send_byte(8'h01);
        exp_err += 2;
        idle(1);
        n_cmp++;
        if (wr_count - c0 !== 1 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL trunc_bad_hdr: got writes=%0d err=%0d want 1 %0d",
                     wr_count - c0, err_count, err_want());
        end
    endtask

    task automatic test_link();
        reg_ready = 1'b0;
        send_byte(8'h84);
        send_byte(8'h01);
        idle(10);
        send_byte(8'h86);
        send_byte(8'h02);
        exp_err++;
        idle(L_CYC - 1 - 12);
        n_cmp++;
        if (link !== 1'b1 || reg_data !== 8'h01) begin
            n_bad++;
            $display("FAIL link_hold: got link=%b data=%h want 1 01", link, reg_data);
        end
        idle(1);
        n_cmp++;
        if (link !== 1'b0 || reg_wr !== 1'b1 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL link_end: got link=%b wr=%b err=%0d want 0 1 %0d",
                     link, reg_wr, err_count, err_want());
        end
        reg_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h11);
            exp_err++;
        end
        n_cmp++;
        if (err_count !== err_want()) begin
            n_bad++;
            $display("FAIL saturate: got %0d want %0d", err_count, err_want());
        end
    endtask

    task automatic test_reset_mid();
        reg_ready = 1'b0;
        send_byte(8'h8C);
        send_byte(8'h44);
        send_byte(8'h87);
        n_cmp++;
        if (reg_wr !== 1'b1 || link !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got wr=%b link=%b want 1 1", reg_wr, link);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({reg_wr, reg_addr, reg_data, link, err_count} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got wr=%b addr=%h data=%h link=%b err=%0d want all 0",
                     reg_wr, reg_addr, reg_data, link, err_count);
        end
        #8;
        rst_n = 1'b1;
        exp_err = 0;
        @(negedge clk);
        reg_ready = 1'b1;
        send_byte(8'h09);
        exp_err++;
        idle(1);
        n_cmp++;
        if (reg_wr !== 1'b0 || err_count !== err_want()) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got wr=%b err=%0d want 0 %0d", reg_wr, err_count, err_want());
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_err = 0; wr_count = 0;
        rst_n = 1'b0;
        test_reset();
        test_write();
        test_d7();
        test_held();
        test_back_to_back();
        test_timeout();
        test_bad_headers();
        test_link();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
